// File: rtl/uart_reg_bridge_if.sv
// Signal bundle between the FT232R adapter handshakes, the register bus and the bridge.
// master = bridge side, slave = adapter/register-file side.
interface uart_reg_bridge_if;
   logic        cmd_req;
   logic        cmd_ack;
   logic [7:0]  cmd_data;
   logic        rsp_req;
   logic        rsp_ack;
   logic [7:0]  rsp_data;
   logic [15:0] reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [15:0] reg_rdata;
   logic        reg_rd_ack;
   logic        frame_err;

   modport master (
      input  cmd_req, cmd_data, rsp_ack, reg_rdata, reg_rd_ack,
      output cmd_ack, rsp_req, rsp_data, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err
   );

   modport slave (
      output cmd_req, cmd_data, rsp_ack, reg_rdata, reg_rd_ack,
      input  cmd_ack, rsp_req, rsp_data, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// Decodes 'W'/'R' register frames from the FT232R byte stream, drives the 16-bit
// register bus and returns ACK/NAK/read-data bytes through the adapter's response side.
module uart_reg_bridge #(
   parameter int P_BYTE_TIMEOUT = 1_250_000,
   parameter int P_RD_TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_reg_bridge_if.master bus
);
   localparam int TO_W = $clog2(P_BYTE_TIMEOUT + 1);
   localparam int RD_W = $clog2(P_RD_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(P_BYTE_TIMEOUT);
   localparam logic [RD_W-1:0] RD_MAX = RD_W'(P_RD_TIMEOUT);
   localparam logic [7:0] OPC_WR  = 8'h57;
   localparam logic [7:0] OPC_RD  = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [3:0] {
      IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, BUS_WR, BUS_RD, WAIT_RD, TX
   } state_t;

   state_t            state_reg, state_next;
   logic              cmd_ack_reg, cmd_ack_next;
   logic [7:0]        byte_reg, byte_next;
   logic              is_wr_reg, is_wr_next;
   logic [15:0]       reg_addr_reg, reg_addr_next;
   logic [15:0]       reg_wdata_reg, reg_wdata_next;
   logic              rsp_req_reg, rsp_req_next;
   logic [7:0]        rsp_data_reg, rsp_data_next;
   logic [15:0]       tx_buf_reg, tx_buf_next;
   logic [1:0]        tx_cnt_reg, tx_cnt_next;
   logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
   logic [RD_W-1:0]   rd_cnt_reg, rd_cnt_next;
   logic              frame_err_reg, frame_err_next;
   logic              rx_state;
   logic              byte_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cmd_ack_reg   <= 1'b0;
         byte_reg      <= '0;
         is_wr_reg     <= 1'b0;
         reg_addr_reg  <= '0;
         reg_wdata_reg <= '0;
         rsp_req_reg   <= 1'b0;
         rsp_data_reg  <= '0;
         tx_buf_reg    <= '0;
         tx_cnt_reg    <= '0;
         to_cnt_reg    <= '0;
         rd_cnt_reg    <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cmd_ack_reg   <= cmd_ack_next;
         byte_reg      <= byte_next;
         is_wr_reg     <= is_wr_next;
         reg_addr_reg  <= reg_addr_next;
         reg_wdata_reg <= reg_wdata_next;
         rsp_req_reg   <= rsp_req_next;
         rsp_data_reg  <= rsp_data_next;
         tx_buf_reg    <= tx_buf_next;
         tx_cnt_reg    <= tx_cnt_next;
         to_cnt_reg    <= to_cnt_next;
         rd_cnt_reg    <= rd_cnt_next;
         frame_err_reg <= frame_err_next;
      end
   end

   // A byte is complete on the cycle the adapter drops cmd_req while we still acknowledge.
   assign rx_state  = (state_reg == IDLE)   || (state_reg == ADDR_H) || (state_reg == ADDR_L) ||
                      (state_reg == DATA_H) || (state_reg == DATA_L);
   assign byte_done = rx_state && cmd_ack_reg && !bus.cmd_req;

   always_comb begin
      state_next     = state_reg;
      cmd_ack_next   = cmd_ack_reg;
      byte_next      = byte_reg;
      is_wr_next     = is_wr_reg;
      reg_addr_next  = reg_addr_reg;
      reg_wdata_next = reg_wdata_reg;
      rsp_req_next   = rsp_req_reg;
      rsp_data_next  = rsp_data_reg;
      tx_buf_next    = tx_buf_reg;
      tx_cnt_next    = tx_cnt_reg;
      to_cnt_next    = to_cnt_reg;
      rd_cnt_next    = rd_cnt_reg;
      frame_err_next = 1'b0;

      if (rx_state) begin
         if (bus.cmd_req && !cmd_ack_reg) begin
            byte_next    = bus.cmd_data;
            cmd_ack_next = 1'b1;
         end else if (cmd_ack_reg && !bus.cmd_req) begin
            cmd_ack_next = 1'b0;
         end
      end

      case (state_reg)
         IDLE: begin
            to_cnt_next = '0;
            if (byte_done) begin
               if (byte_reg == OPC_WR || byte_reg == OPC_RD) begin
                  is_wr_next = (byte_reg == OPC_WR);
                  state_next = ADDR_H;
               end else begin
                  frame_err_next = 1'b1;
                  tx_buf_next    = {RSP_NAK, 8'h00};
                  tx_cnt_next    = 2'd1;
                  state_next     = TX;
               end
            end
         end
         ADDR_H, ADDR_L, DATA_H, DATA_L: begin
            if (byte_done) begin
               to_cnt_next = '0;
               case (state_reg)
                  ADDR_H: begin
                     reg_addr_next[15:8] = byte_reg;
                     state_next          = ADDR_L;
                  end
                  ADDR_L: begin
                     reg_addr_next[7:0] = byte_reg;
                     state_next         = is_wr_reg ? DATA_H : BUS_RD;
                  end
                  DATA_H: begin
                     reg_wdata_next[15:8] = byte_reg;
                     state_next           = DATA_L;
                  end
                  default: begin
                     reg_wdata_next[7:0] = byte_reg;
                     state_next          = BUS_WR;
                  end
               endcase
            end else if (!cmd_ack_reg) begin
               // Inter-byte gap: drop the frame silently once the gap gets too long.
               if (to_cnt_reg == TO_MAX) begin
                  frame_err_next = 1'b1;
                  to_cnt_next    = '0;
                  state_next     = IDLE;
               end else begin
                  to_cnt_next = to_cnt_reg + TO_W'(1);
               end
            end
         end
         BUS_WR: begin
            tx_buf_next = {RSP_ACK, 8'h00};
            tx_cnt_next = 2'd1;
            state_next  = TX;
         end
         BUS_RD: begin
            rd_cnt_next = RD_W'(1);
            if (bus.reg_rd_ack) begin
               tx_buf_next = bus.reg_rdata;
               tx_cnt_next = 2'd2;
               state_next  = TX;
            end else begin
               state_next = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (bus.reg_rd_ack) begin
               tx_buf_next = bus.reg_rdata;
               tx_cnt_next = 2'd2;
               state_next  = TX;
            end else if (rd_cnt_reg == RD_MAX) begin
               frame_err_next = 1'b1;
               tx_buf_next    = {RSP_NAK, 8'h00};
               tx_cnt_next    = 2'd1;
               state_next     = TX;
            end else begin
               rd_cnt_next = rd_cnt_reg + RD_W'(1);
            end
         end
         TX: begin
            // rsp_req spends at least one cycle low between bytes, so every byte gets a fresh rising edge.
            if (!rsp_req_reg) begin
               rsp_req_next  = 1'b1;
               rsp_data_next = tx_buf_reg[15:8];
            end else if (bus.rsp_ack) begin
               rsp_req_next = 1'b0;
               tx_buf_next  = {tx_buf_reg[7:0], 8'h00};
               tx_cnt_next  = tx_cnt_reg - 2'd1;
               if (tx_cnt_reg == 2'd1) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.cmd_ack   = cmd_ack_reg;
   assign bus.rsp_req   = rsp_req_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.reg_addr  = reg_addr_reg;
   assign bus.reg_wdata = reg_wdata_reg;
   assign bus.reg_wr    = (state_reg == BUS_WR);
   assign bus.reg_rd    = (state_reg == BUS_RD);
   assign bus.frame_err = frame_err_reg;
endmodule
